apb_sram_arbiter: RTL and testbench



---
 rtl/apb_sram_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 35 +++
 rtl/apb_sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_sram_arbiter.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the multi-requester APB SRAM master.
package apb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_mst_state_e;

    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module apb_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int w_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (en && !any && req[IDX_W'(w_idx)]) begin
                any                        = 1'b1;
                gnt_idx                    = IDX_W'(w_idx);
                gnt_onehot[IDX_W'(w_idx)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_sram_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS sequencing,
// PREADY watchdog, and one-hot response return to the granted requester.
module apb_sram_arbiter
    import apb_sram_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int ADDR_BUS_WIDTH = 32,
    parameter  int DATA_BUS_WIDTH = 32,
    parameter  int TIMEOUT_CYC    = 16,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_BUS_WIDTH-1:0]         rsp_rdata,
    output logic                              rsp_err,
    output logic [IDX_W-1:0]                  grant_id,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic                              PWRITE,
    output logic [ADDR_BUS_WIDTH-1:0]         PADDR,
    output logic [DATA_BUS_WIDTH-1:0]         PWDATA,
    input  logic [DATA_BUS_WIDTH-1:0]         PRDATA,
    input  logic                              PREADY,
    input  logic                              PSLVERR
);

    localparam int CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    apb_mst_state_e              r_state;
    apb_mst_state_e              w_next_state;
    logic [IDX_W-1:0]            r_ptr;
    logic [IDX_W-1:0]            r_grant_id;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_pwrite;
    logic [ADDR_BUS_WIDTH-1:0]   r_paddr;
    logic [DATA_BUS_WIDTH-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]          r_rsp_valid;
    logic [DATA_BUS_WIDTH-1:0]   r_rsp_rdata;
    logic                        r_rsp_err;

    logic [NUM_REQ-1:0]          w_gnt_onehot;
    logic [IDX_W-1:0]            w_gnt_idx;
    logic                        w_gnt_any;
    logic                        w_arb_en;
    logic                        w_timeout;
    logic                        w_done;
    logic                        w_sel_write;
    logic [ADDR_BUS_WIDTH-1:0]   w_sel_addr;
    logic [DATA_BUS_WIDTH-1:0]   w_sel_wdata;

    // Gated by PRESET so req_ready stays low while reset is held.
    assign w_arb_en = (r_state == ST_IDLE) && !PRESET;

    apb_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (r_ptr),
        .en         (w_arb_en),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_gnt_any)
    );

    always_comb begin
        w_sel_write = APB_READ;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
            end
        end
    end

    // Watchdog fires in the last allowed ACCESS cycle; PREADY in that same cycle still wins.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TO_LAST));

    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_gnt_any) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY || w_timeout) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state     <= w_next_state;
            r_rsp_valid <= '0;

            if (w_arb_en && w_gnt_any) begin
                r_pwrite   <= w_sel_write;
                r_paddr    <= w_sel_addr;
                r_pwdata   <= w_sel_wdata;
                r_grant_id <= w_gnt_idx;
                r_ptr      <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end

            if (r_state == ST_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_done) begin
                r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
                if (PREADY) begin
                    r_rsp_err   <= PSLVERR;
                    r_rsp_rdata <= (r_pwrite == APB_WRITE) ? '0 : PRDATA;
                end else begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
            end
        end
    end

    assign req_ready = w_gnt_onehot;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign grant_id  = r_grant_id;
    assign PSEL      = (r_state != ST_IDLE);
    assign PENABLE   = (r_state == ST_ACCESS);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Self-checking bench for apb_sram_arbiter with a 64-word APB SRAM slave stub and a reference model.
`timescale 1ns/1ps
module tb_apb_sram_arbiter;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEMSIZE = 64;
    localparam int NTX     = 60;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [1:0]        grant_id;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA, PRDATA;
    logic              PREADY, PSLVERR;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic [DW-1:0] slv_mem   [MEMSIZE];
    logic [DW-1:0] model_mem [MEMSIZE];
    int            slv_wait  = 0;
    bit            slv_stall = 1'b0;
    int            slv_cnt   = 0;

    apb_sram_arbiter #(
        .NUM_REQ(N), .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .TIMEOUT_CYC(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // SRAM slave stub: answers on the falling edge so the master samples a settled response.
    always @(negedge PCLK or posedge PRESET) begin
        if (PRESET || !(PSEL && PENABLE)) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            slv_cnt = 0;
        end else if (!slv_stall && slv_cnt >= slv_wait) begin
            PREADY  = 1'b1;
            PSLVERR = (PADDR >= MEMSIZE);
            if (PADDR >= MEMSIZE) begin
                PRDATA = '0;
            end else if (PWRITE) begin
                slv_mem[PADDR[5:0]] = PWDATA;
                PRDATA = $urandom;
            end else begin
                PRDATA = slv_mem[PADDR[5:0]];
            end
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            slv_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        slv_wait  = 0;
        slv_stall = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        while ((PSEL || rsp_valid != '0) && n < 40) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic run_xfer(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output logic er, output int lat);
        int n;
        int t0;
        set_cmd(i, wr, a, d);
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL xfer_accept req%0d: no req_ready after %0d cycles, want accept", i, n);
        end
        t0 = int'(cyc);
        tick();
        req_valid[i] = 1'b0;
        n = 0;
        while (rsp_valid[i] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL xfer_rsp req%0d: no rsp_valid after %0d cycles, want response", i, n);
        end
        rd  = rsp_rdata;
        er  = rsp_err;
        lat = int'(cyc) - t0;
    endtask

    task automatic test_reset();
        PRESET    = 1'b1;
        req_valid = '1;
        req_write = '1;
        req_addr  = '1;
        req_wdata = '1;
        #1;
        total++;
        if ({PSEL, PENABLE, PWRITE, rsp_err, req_ready, rsp_valid, grant_id} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got sel=%b en=%b wr=%b err=%b rdy=%b rv=%b gid=%0d, want all 0",
                     PSEL, PENABLE, PWRITE, rsp_err, req_ready, rsp_valid, grant_id);
        end
        @(posedge PCLK);
        #1;
        total++;
        if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0 || req_ready !== '0) begin
            bad++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h rdy=%b, want 0", PADDR, PWDATA, rsp_rdata, req_ready);
        end
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRESET    = 1'b0;
        #1;
        total++;
        if ({PSEL, PENABLE, req_ready, rsp_valid} !== '0) begin
            bad++;
            $display("FAIL reset_release: got sel=%b en=%b rdy=%b rv=%b, want 0", PSEL, PENABLE, req_ready, rsp_valid);
        end
    endtask

    task automatic test_single_wr_rd();
        set_cmd(2, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL wr_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid[2] = 1'b0;
        total++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h5 || PWDATA !== 32'hDEAD_BEEF || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL wr_setup: got sel/en/wr=%b%b%b addr=%h data=%h gid=%0d, want 101 5 deadbeef 2",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, grant_id);
        end
        tick();
        total++;
        if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== '0) begin
            bad++;
            $display("FAIL wr_access: got sel/en=%b%b rv=%b, want 11 0000", PSEL, PENABLE, rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_rdata !== '0 || PSEL !== 1'b0) begin
            bad++;
            $display("FAIL wr_rsp_c3: got rv=%b err=%b rdata=%h sel=%b, want 0100 0 0 0", rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
        model_mem[5] = 32'hDEAD_BEEF;
        set_cmd(2, 1'b0, 32'h0000_0005, 32'h0);
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rd_ready_in_c3: got %b want 0100", req_ready);
        end
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        total++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rd_rsp_c3: got rv=%b rdata=%h err=%b, want 0100 deadbeef 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] rd;
        logic          er;
        int            lat;
        run_xfer(0, 1'b0, 32'h40, '0, rd, er, lat);
        total++;
        if (er !== 1'b1 || lat != 3) begin
            bad++;
            $display("FAIL oor_err: got err=%b lat=%0d, want 1 3", er, lat);
        end
        run_xfer(1, 1'b0, 32'h5, '0, rd, er, lat);
        total++;
        if (er !== 1'b0 || rd !== model_mem[5] || lat != 3) begin
            bad++;
            $display("FAIL oor_next: got err=%b rdata=%h lat=%0d, want 0 %h 3", er, rd, lat, model_mem[5]);
        end
    endtask

    task automatic test_timeout();
        int n;
        slv_stall = 1'b1;
        set_cmd(3, 1'b0, 32'h7, '0);
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL to_ready: got %b want 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        tick();
        n = 0;
        while (PSEL && PENABLE && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL to_access_cycles: got %0d want 16", n);
        end
        total++;
        if (PSEL !== 1'b0 || rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
            bad++;
            $display("FAIL to_rsp: got sel=%b rv=%b err=%b rdata=%h, want 0 1000 1 0", PSEL, rsp_valid, rsp_err, rsp_rdata);
        end
        slv_stall = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        logic          er;
        int            lat;
        int            n_acc;
        int            n;
        bit            stable;
        a        = AW'($urandom_range(0, MEMSIZE - 1));
        d        = $urandom;
        slv_wait = 2;
        set_cmd(1, 1'b1, a, d);
        #1;
        tick();
        req_valid[1] = 1'b0;
        stable = 1'b1;
        n_acc  = 0;
        n      = 0;
        while (PSEL && n < 20) begin
            if (PADDR !== a || PWDATA !== d || PWRITE !== 1'b1 || rsp_valid !== '0) stable = 1'b0;
            if (PENABLE) n_acc++;
            n++;
            tick();
        end
        total++;
        if (!stable || n_acc != 3) begin
            bad++;
            $display("FAIL ws_access: got stable=%0b access_cycles=%0d, want 1 3", stable, n_acc);
        end
        total++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL ws_rsp: got rv=%b err=%b, want 0010 0", rsp_valid, rsp_err);
        end
        model_mem[a[5:0]] = d;
        slv_wait = 0;
        run_xfer(1, 1'b0, a, '0, rd, er, lat);
        total++;
        if (rd !== d || er !== 1'b0 || lat != 3) begin
            bad++;
            $display("FAIL ws_readback: got rdata=%h err=%b lat=%0d, want %h 0 3", rd, er, lat, d);
        end
    endtask

    task automatic test_round_robin();
        int g[$];
        int rc[$];
        int ri[$];
        int n;
        PRESET = 1'b1;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i), '0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        #1;
        n = 0;
        while ((g.size() < 5 || rc.size() < 4) && n < 40) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) g.push_back(i);
                if (rsp_valid[i]) begin
                    rc.push_back(int'(cyc));
                    ri.push_back(i);
                end
            end
            tick();
            n++;
        end
        total++;
        if (g.size() < 5 || rc.size() < 4) begin
            bad++;
            $display("FAIL rr_progress: got grants=%0d rsps=%0d, want 5 4", g.size(), rc.size());
        end
        for (int k = 0; k < 5 && k < g.size(); k++) begin
            total++;
            if (g[k] != k % N) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, g[k], k % N);
            end
        end
        for (int k = 0; k + 1 < 4 && k + 1 < rc.size(); k++) begin
            total++;
            if (rc[k+1] - rc[k] != 3 || ri[k] != k) begin
                bad++;
                $display("FAIL rr_rsp_spacing[%0d]: got gap=%0d req=%0d want 3 %0d", k, rc[k+1] - rc[k], ri[k], k);
            end
        end
        drain();
    endtask

    task automatic test_random();
        bit            pend   [N];
        bit            outst  [N];
        bit            acc    [N];
        logic          c_wr   [N];
        logic [AW-1:0] c_addr [N];
        logic [DW-1:0] c_data [N];
        logic [DW-1:0] e_rd   [N];
        logic          e_er   [N];
        logic [N-1:0]  e_gnt;
        bit            busy;
        bit            found;
        int            ptr;
        int            done;
        int            issued;
        int            w;
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            outst[i] = 1'b0;
            acc[i]   = 1'b0;
        end
        busy   = 1'b0;
        ptr    = 0;
        done   = 0;
        issued = 0;
        for (int c = 0; c < 4000 && done < NTX; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    total++;
                    if (!outst[i] || rsp_rdata !== e_rd[i] || rsp_err !== e_er[i]) begin
                        bad++;
                        $display("FAIL rand_rsp req%0d: outstanding=%0b rdata=%h want %h err=%b want %b",
                                 i, outst[i], rsp_rdata, e_rd[i], rsp_err, e_er[i]);
                    end
                    outst[i] = 1'b0;
                    busy     = 1'b0;
                    done++;
                end
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i]       = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !outst[i] && issued < NTX && $urandom_range(0, 2) == 0) begin
                    c_wr[i]   = 1'($urandom_range(0, 1));
                    c_addr[i] = AW'($urandom_range(0, MEMSIZE + 7));
                    c_data[i] = $urandom;
                    set_cmd(i, c_wr[i], c_addr[i], c_data[i]);
                    pend[i] = 1'b1;
                    issued++;
                end
            end
            slv_wait = $urandom_range(0, 2);
            #1;
            e_gnt = '0;
            found = 1'b0;
            w     = 0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && pend[(ptr + k) % N]) begin
                        found = 1'b1;
                        w     = (ptr + k) % N;
                    end
                end
            end
            if (found) e_gnt[w] = 1'b1;
            total++;
            if (req_ready !== e_gnt) begin
                bad++;
                $display("FAIL rand_grant cyc%0d: got %b want %b", cyc, req_ready, e_gnt);
            end
            if (found) begin
                e_er[w] = (c_addr[w] >= MEMSIZE);
                e_rd[w] = (c_wr[w] || e_er[w]) ? '0 : model_mem[c_addr[w][5:0]];
                if (c_wr[w] && !e_er[w]) model_mem[c_addr[w][5:0]] = c_data[w];
                pend[w]  = 1'b0;
                outst[w] = 1'b1;
                acc[w]   = 1'b1;
                busy     = 1'b1;
                ptr      = (w + 1) % N;
            end
            tick();
        end
        total++;
        if (done != NTX) begin
            bad++;
            $display("FAIL rand_complete: got %0d responses want %0d", done, NTX);
        end
        slv_wait = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen2;
        do_reset();
        set_cmd(2, 1'b0, 32'h3, '0);
        #1;
        n = 0;
        while (!PENABLE && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL rm_reach_access: got penable=%b want 1", PENABLE);
        end
        PRESET = 1'b1;
        #1;
        total++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== '0) begin
            bad++;
            $display("FAIL rm_async: got sel=%b en=%b rv=%b rdy=%b, want 0", PSEL, PENABLE, rsp_valid, req_ready);
        end
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i), '0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rm_first_grant: got %b want 0001", req_ready);
        end
        seen2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid[2]) seen2 = 1'b1;
        end
        total++;
        if (seen2) begin
            bad++;
            $display("FAIL rm_dropped: got rsp_valid for dropped req2 transfer, want none");
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < MEMSIZE; i++) begin
            slv_mem[i]   = '0;
            model_mem[i] = '0;
        end
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        test_reset();
        test_single_wr_rd();
        test_out_of_range();
        test_timeout();
        test_wait_states();
        test_round_robin();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
